// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states,
// operand bundle and wait-counter helpers.
package alu_arbiter_pkg;

  // Default number of cycles operands are held on the ALU before sampling.
  localparam int unsigned AluWaitDefault = 2;

  // Wait counter width; covers the legal ALU_WAIT range 1..15.
  localparam int unsigned CntW = 4;

  // Op codes understood by the shared ALU. The arbiter never decodes them.
  typedef enum logic [2:0] {
    OpForward = 3'b000,
    OpAdd     = 3'b001,
    OpAnd     = 3'b010,
    OpOr      = 3'b011
  } alu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Operands as presented to the ALU.
  typedef struct packed {
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] select;
  } operands_t;

  // Counter load value: the grant cycle itself counts as the first wait cycle.
  function automatic logic [CntW-1:0] wait_load(input int unsigned alu_wait);
    return CntW'(alu_wait - 1);
  endfunction

endpackage

// File: rtl/alu.sv
// Simple shared ALU: combinational, 8-bit, four op codes; others yield zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  input  logic [2:0] select_i,
  output logic [7:0] result_o
);

  // Decode op code into the combinational result.
  always_comb begin
    result_o = 8'h00;
    case (select_i)
      OpForward: result_o = data1_i;
      OpAdd:     result_o = data1_i + data2_i;
      OpAnd:     result_o = data1_i & data2_i;
      OpOr:      result_o = data1_i | data2_i;
      default:   result_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection with a last-grant pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic last_q;
  logic last_d;
  logic winner;

  // Single requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    winner = 1'b0;
    unique case (req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  // Pointer tracks the winner of every accepted grant.
  always_comb begin
    last_d = last_q;
    if (update_i && (|req_i)) begin
      last_d = winner;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign valid_o  = |req_i;
  assign winner_o = winner;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared, externally instantiated ALU.
// Operands are held for ALU_WAIT cycles, then the ALU result is registered.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  // Legal range 1..15.
  parameter int unsigned ALU_WAIT = AluWaitDefault
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] data1_0_i,
  input  logic [7:0] data2_0_i,
  input  logic [7:0] data1_1_i,
  input  logic [7:0] data2_1_i,
  input  logic [2:0] select0_i,
  input  logic [2:0] select1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic [7:0] alu_data1_o,
  output logic [7:0] alu_data2_o,
  output logic [2:0] alu_select_o,
  input  logic [7:0] alu_result_i,
  output logic [7:0] result_o,
  output logic       result_valid_o,
  output logic       result_id_o
);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  operands_t       ops_q;
  operands_t       ops_d;
  logic            owner_q;
  logic            gnt0_q;
  logic            gnt1_q;
  logic [7:0]      result_q;
  logic            result_valid_q;
  logic            result_id_q;

  logic            arb_en;
  logic            req_any;
  logic            winner;

  // Arbitration only counts while idle; requests during BUSY are ignored.
  assign arb_en = (state_q == StIdle);

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .req_i    ({req1_i, req0_i}),
    .update_i (arb_en),
    .valid_o  (req_any),
    .winner_o (winner)
  );

  // Operand mux selecting the current winner's inputs.
  always_comb begin
    ops_d = '{data1: data1_0_i, data2: data2_0_i, select: select0_i};
    if (winner) begin
      ops_d = '{data1: data1_1_i, data2: data2_1_i, select: select1_i};
    end
  end

  // Control FSM, wait counter and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      ops_q          <= '0;
      owner_q        <= 1'b0;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      result_id_q    <= 1'b0;
    end else begin
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            ops_q   <= ops_d;
            owner_q <= winner;
            gnt0_q  <= ~winner;
            gnt1_q  <= winner;
            cnt_q   <= wait_load(ALU_WAIT);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            result_q       <= alu_result_i;
            result_id_q    <= owner_q;
            result_valid_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0_o         = gnt0_q;
  assign gnt1_o         = gnt1_q;
  assign alu_data1_o    = ops_q.data1;
  assign alu_data2_o    = ops_q.data2;
  assign alu_select_o   = ops_q.select;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign result_id_o    = result_id_q;

  gnt_exclusive_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(gnt0_q && gnt1_q));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: ALU_WAIT=2 instance (A) and ALU_WAIT=1 instance (B).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int WaitA = 2;
  localparam int WaitB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       req0_a, req1_a, gnt0_a, gnt1_a, valid_a, id_a;
  logic [7:0] d1_0_a, d2_0_a, d1_1_a, d2_1_a, alu_d1_a, alu_d2_a, alu_res_a, result_a;
  logic [2:0] sel0_a, sel1_a, alu_sel_a;

  logic       req0_b, req1_b, gnt0_b, gnt1_b, valid_b, id_b;
  logic [7:0] d1_0_b, d2_0_b, d1_1_b, d2_1_b, alu_d1_b, alu_d2_b, alu_res_b, result_b;
  logic [2:0] sel0_b, sel1_b, alu_sel_b;

  alu_arbiter #(.ALU_WAIT(WaitA)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .req0_i(req0_a), .req1_i(req1_a),
    .data1_0_i(d1_0_a), .data2_0_i(d2_0_a), .data1_1_i(d1_1_a), .data2_1_i(d2_1_a),
    .select0_i(sel0_a), .select1_i(sel1_a), .gnt0_o(gnt0_a), .gnt1_o(gnt1_a),
    .alu_data1_o(alu_d1_a), .alu_data2_o(alu_d2_a), .alu_select_o(alu_sel_a),
    .alu_result_i(alu_res_a), .result_o(result_a), .result_valid_o(valid_a),
    .result_id_o(id_a)
  );

  alu u_alu_a (
    .data1_i(alu_d1_a), .data2_i(alu_d2_a), .select_i(alu_sel_a), .result_o(alu_res_a)
  );

  alu_arbiter #(.ALU_WAIT(WaitB)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .req0_i(req0_b), .req1_i(req1_b),
    .data1_0_i(d1_0_b), .data2_0_i(d2_0_b), .data1_1_i(d1_1_b), .data2_1_i(d2_1_b),
    .select0_i(sel0_b), .select1_i(sel1_b), .gnt0_o(gnt0_b), .gnt1_o(gnt1_b),
    .alu_data1_o(alu_d1_b), .alu_data2_o(alu_d2_b), .alu_select_o(alu_sel_b),
    .alu_result_i(alu_res_b), .result_o(result_b), .result_valid_o(valid_b),
    .result_id_o(id_b)
  );

  alu u_alu_b (
    .data1_i(alu_d1_b), .data2_i(alu_d2_b), .select_i(alu_sel_b), .result_o(alu_res_b)
  );

  typedef struct {
    logic       id;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   glog_id[$];
  int   glog_cyc[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_valid_a = 0;

  logic [7:0] exp_res0, exp_res1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a result.
  exp_t e_a, e_b;
  logic pv_a = 1'b0, pv_b = 1'b0;
  logic pg0_a = 1'b0, pg1_a = 1'b0, pg0_b = 1'b0, pg1_b = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        n_valid_a++;
        chk("valid_a_pulse", {31'd0, pv_a}, 32'd0);
        if (sb_a.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid_a: got result 0x%0h id %0d, expected none", result_a,
                   id_a);
        end else begin
          e_a = sb_a.pop_front();
          chk("result_a", {24'd0, result_a}, {24'd0, e_a.res});
          chk("result_id_a", {31'd0, id_a}, {31'd0, e_a.id});
          chk("latency_a", cyc, e_a.cyc);
        end
      end
      pv_a = valid_a;
      if ((gnt0_a | gnt1_a) === 1'b1) begin
        chk("gnt_excl_a", {31'd0, gnt0_a & gnt1_a}, 32'd0);
        chk("gnt_pulse_a", {31'd0, (gnt0_a & pg0_a) | (gnt1_a & pg1_a)}, 32'd0);
      end
      pg0_a = gnt0_a;
      pg1_a = gnt1_a;

      if (valid_b === 1'b1) begin
        chk("valid_b_pulse", {31'd0, pv_b}, 32'd0);
        if (sb_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid_b: got result 0x%0h id %0d, expected none", result_b,
                   id_b);
        end else begin
          e_b = sb_b.pop_front();
          chk("result_b", {24'd0, result_b}, {24'd0, e_b.res});
          chk("result_id_b", {31'd0, id_b}, {31'd0, e_b.id});
          chk("latency_b", cyc, e_b.cyc);
        end
      end
      pv_b = valid_b;
      if ((gnt0_b | gnt1_b) === 1'b1) begin
        chk("gnt_excl_b", {31'd0, gnt0_b & gnt1_b}, 32'd0);
        chk("gnt_pulse_b", {31'd0, (gnt0_b & pg0_b) | (gnt1_b & pg1_b)}, 32'd0);
      end
      pg0_b = gnt0_b;
      pg1_b = gnt1_b;
    end
  end

  task automatic chk_hold_a(input string name, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [2:0] sel);
    chk({name, "_d1"}, {24'd0, alu_d1_a}, {24'd0, d1});
    chk({name, "_d2"}, {24'd0, alu_d2_a}, {24'd0, d2});
    chk({name, "_sel"}, {29'd0, alu_sel_a}, {29'd0, sel});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise requests, push expectations at each grant, drop a request once its ops are done.
  task automatic run_ops(input int n0, input int n1);
    int left0 = n0;
    int left1 = n1;
    int budget = 0;
    int busy_left = 0;
    logic [7:0] bd1 = 8'h00, bd2 = 8'h00;
    logic [2:0] bsel = 3'b000;
    req0_a = (n0 > 0);
    req1_a = (n1 > 0);
    while ((left0 > 0 || left1 > 0) && budget < 100) begin
      @(negedge clk);
      budget++;
      if (busy_left > 0) begin
        chk_hold_a("alu_busy", bd1, bd2, bsel);
        busy_left--;
      end
      if (gnt0_a === 1'b1) begin
        sb_a.push_back('{id: 1'b0, res: exp_res0, cyc: cyc + WaitA});
        glog_id.push_back(0);
        glog_cyc.push_back(cyc);
        bd1 = d1_0_a; bd2 = d2_0_a; bsel = sel0_a;
        chk_hold_a("alu_gnt0", bd1, bd2, bsel);
        busy_left = WaitA - 1;
        left0--;
        if (left0 <= 0) req0_a = 1'b0;
      end
      if (gnt1_a === 1'b1) begin
        sb_a.push_back('{id: 1'b1, res: exp_res1, cyc: cyc + WaitA});
        glog_id.push_back(1);
        glog_cyc.push_back(cyc);
        bd1 = d1_1_a; bd2 = d2_1_a; bsel = sel1_a;
        chk_hold_a("alu_gnt1", bd1, bd2, bsel);
        busy_left = WaitA - 1;
        left1--;
        if (left1 <= 0) req1_a = 1'b0;
      end
    end
    if (left0 > 0 || left1 > 0) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got %0d/%0d grants outstanding, expected 0/0", left0, left1);
      req0_a = 1'b0;
      req1_a = 1'b0;
    end
    for (int i = 0; i < WaitA + 2; i++) begin
      @(negedge clk);
      if (busy_left > 0) begin
        chk_hold_a("alu_busy", bd1, bd2, bsel);
        busy_left--;
      end
    end
    chk_hold_a("alu_idle_hold", bd1, bd2, bsel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int nv;
    logic seen;
    reset  = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    d1_0_a = 8'h00; d2_0_a = 8'h00; d1_1_a = 8'h00; d2_1_a = 8'h00;
    sel0_a = 3'b000; sel1_a = 3'b000;
    d1_0_b = 8'h00; d2_0_b = 8'h00; d1_1_b = 8'h00; d2_1_b = 8'h00;
    sel0_b = 3'b000; sel1_b = 3'b000;
    exp_res0 = 8'h00; exp_res1 = 8'h00;

    // Reset for two cycles, then ten quiet cycles with all outputs at zero.
    @(negedge clk);
    do_reset();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | gnt0_a | gnt1_a | valid_a;
    end
    chk("rst_no_activity", {31'd0, seen}, 32'd0);
    chk("rst_result", {24'd0, result_a}, 32'd0);
    chk("rst_result_id", {31'd0, id_a}, 32'd0);
    chk_hold_a("rst_alu", 8'h00, 8'h00, 3'b000);
    chk("rst_outs_b", {alu_d1_b, alu_d2_b, result_b, 3'd0, alu_sel_b, gnt0_b, gnt1_b, valid_b,
                       id_b}, 32'd0);

    // Single add from requester 0.
    d1_0_a = 8'h03; d2_0_a = 8'hFA; sel0_a = 3'b001; exp_res0 = 8'hFD;
    run_ops(1, 0);

    // Unknown op code passes through untouched; the ALU returns zero for it.
    d1_0_a = 8'h12; d2_0_a = 8'h34; sel0_a = 3'b101; exp_res0 = 8'h00;
    run_ops(1, 0);

    // Simultaneous requests after reset: requester 0 wins the first tie.
    do_reset();
    glog_id.delete(); glog_cyc.delete();
    d1_0_a = 8'h03; d2_0_a = 8'h02; sel0_a = 3'b010; exp_res0 = 8'h02;
    d1_1_a = 8'h05; d2_1_a = 8'h02; sel1_a = 3'b011; exp_res1 = 8'h07;
    run_ops(1, 1);
    chk("tie_order_len", glog_id.size(), 2);
    if (glog_id.size() == 2) begin
      chk("tie_first", glog_id[0], 0);
      chk("tie_second", glog_id[1], 1);
    end

    // Both held for four operations: strict alternation, one grant every three cycles.
    glog_id.delete(); glog_cyc.delete();
    d1_0_a = 8'h03; d2_0_a = 8'hFA; sel0_a = 3'b001; exp_res0 = 8'hFD;
    run_ops(2, 2);
    chk("rr_len", glog_id.size(), 4);
    if (glog_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_order_%0d", i), glog_id[i], i % 2);
        if (i > 0) chk($sformatf("rr_period_%0d", i), glog_cyc[i] - glog_cyc[i-1], WaitA + 1);
      end
    end

    // Reset in the cycle after GNT1 discards the operation.
    d1_1_a = 8'h10; d2_1_a = 8'h20; sel1_a = 3'b001;
    req1_a = 1'b1;
    budget = 0;
    while (gnt1_a !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("abort_gnt1_seen", {31'd0, gnt1_a}, 32'd1);
    req1_a = 1'b0;
    nv = n_valid_a;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_valid", n_valid_a - nv, 0);
    chk("abort_result_cleared", {24'd0, result_a}, 32'd0);
    chk_hold_a("abort_alu_cleared", 8'h00, 8'h00, 3'b000);

    d1_0_a = 8'h83; d2_0_a = 8'h00; sel0_a = 3'b000; exp_res0 = 8'h83;
    run_ops(1, 0);

    // ALU_WAIT=1 instance: forward from requester 1.
    d1_1_b = 8'h83; d2_1_b = 8'h00; sel1_b = 3'b000;
    req1_b = 1'b1;
    budget = 0;
    while (gnt1_b !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("b_gnt1_seen", {31'd0, gnt1_b}, 32'd1);
    sb_b.push_back('{id: 1'b1, res: 8'h83, cyc: cyc + WaitB});
    req1_b = 1'b0;
    chk("b_alu_busy", {alu_d1_b, alu_d2_b, 13'd0, alu_sel_b}, {8'h83, 8'h00, 16'd0});
    @(negedge clk);
    chk("b_alu_hold", {alu_d1_b, alu_d2_b, 13'd0, alu_sel_b}, {8'h83, 8'h00, 16'd0});
    repeat (3) @(negedge clk);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_WAIT, default 2, number of clock cycles operands are held on the ALU before RESULT is sampled (legal range 1..15).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 REQ0 / REQ1  input  1 each  requester 0/1 operation request; held high until its GNT is seen.
REQ-005 DATA1_0, DATA2_0 / DATA1_1, DATA2_1  input  8 each  signed operands of requester 0/1.
REQ-006 SELECT0 / SELECT1  input  3 each  ALU op code of requester 0/1 (000 forward, 001 add, 010 and, 011 or).
REQ-007 GNT0 / GNT1  output  1 each  one-cycle pulse: request accepted and operands latched.
REQ-008 ALU_DATA1, ALU_DATA2  output  8 each  operands driven to the shared ALU.
REQ-009 ALU_SELECT  output  3  op code driven to the shared ALU.
REQ-010 ALU_RESULT  input  8  combinational result returned by the shared ALU.
REQ-011 RESULT  output  8  registered ALU result of the completed operation.
REQ-012 RESULT_VALID  output  1  one-cycle pulse marking RESULT as new.
REQ-013 RESULT_ID  output  1  requester index owning RESULT.

Function
REQ-014 FSM has exactly two states: IDLE and BUSY.
REQ-015 IDLE, no REQ high: remain IDLE, all GNT low.
REQ-016 IDLE, at least one REQ high at a rising edge: winner's DATA1/DATA2/SELECT latched into operand registers, owner ID latched, winner's GNT high for the next cycle only, state -> BUSY, wait counter loaded with ALU_WAIT-1.
REQ-017 Only one REQ high: that requester wins.
REQ-018 Both REQ high: requester not granted last wins (round-robin); last-grant pointer updated to winner on every grant.
REQ-019 ALU_DATA1/ALU_DATA2/ALU_SELECT driven directly from operand registers; stable throughout BUSY; hold last values in IDLE.
REQ-020 BUSY, counter nonzero: counter decrements by 1 per cycle; REQ inputs ignored.
REQ-021 BUSY, counter zero at a rising edge: RESULT <= ALU_RESULT, RESULT_ID <= owner ID, RESULT_VALID high for the next cycle only, state -> IDLE.
REQ-022 Latency: RESULT_VALID rises exactly ALU_WAIT cycles after the cycle GNT rises; throughput one operation per ALU_WAIT+1 cycles.
REQ-023 A new grant is allowed in the same cycle RESULT_VALID is high (back-to-back).
REQ-024 RESULT and RESULT_ID hold their value until the next completion.
REQ-025 SELECT values 100..111 pass through unmodified; the arbiter does not interpret op codes.
REQ-026 Requester keeping REQ high after its GNT is treated as a new request at the next IDLE arbitration.
REQ-027 GNT0 and GNT1 are never high in the same cycle.

Reset
REQ-028 RESET high at a rising edge: state IDLE, counter 0, last-grant pointer = 1 (requester 0 wins the first tie).
REQ-029 RESET also clears GNT0, GNT1, RESULT_VALID, RESULT, RESULT_ID, ALU_DATA1, ALU_DATA2, ALU_SELECT to 0.
REQ-030 RESET during BUSY discards the in-flight operation; no RESULT_VALID is produced for it.
REQ-031 RESET has priority over every other event in the same cycle.

Structure
REQ-032 Shared definitions file holds the ALU op codes (FORWARD, ADD, AND, OR), FSM state encodings, and ALU_WAIT default.
REQ-033 Round-robin winner selection plus last-grant pointer is one sub-module, rr_arb2; FSM, counter and datapath registers remain in alu_arbiter.
REQ-034 The ALU is instantiated outside alu_arbiter; the bench connects the existing alu module to the ALU_* ports.

Verification
REQ-035 RESET high 2 cycles, all REQ low -> every output 0, no GNT for 10 further cycles.
REQ-036 REQ0 only, DATA1_0=8'h03, DATA2_0=8'hFA, SELECT0=001 -> GNT0 one pulse; ALU_WAIT=2 cycles later RESULT=8'hFD, RESULT_ID=0, RESULT_VALID one pulse.
REQ-037 REQ0 (03 AND 02, SELECT 010) and REQ1 (05 OR 02, SELECT 011) raised same cycle after reset -> GNT0 first, RESULT 8'h02 ID 0; then GNT1, RESULT 8'h07 ID 1.
REQ-038 REQ0 and REQ1 held high for 4 operations -> grant order 0,1,0,1; RESULT_VALID period 3 cycles with ALU_WAIT=2.
REQ-039 RESET pulsed in the cycle after GNT1 -> no RESULT_VALID; a following REQ0 forward of 8'h83 completes with RESULT=8'h83, ID 0.
REQ-040 ALU_WAIT=1, REQ1 forward 8'h83 -> RESULT_VALID one cycle after GNT1, ALU_* outputs stable while BUSY.
